apb4_cpuif_initiator: RTL and testbench

APB4 requester that drives the CPU interface of a generated register block from a simple valid/ready command channel. It sits on the bus-master side of the regblock in simulation benches and SoC integration, converting one command at a time into an APB SETUP/ACCESS sequence and returning read data, error and timeout status on a response channel. A programmable watchdog aborts transfers whose responder never asserts PREADY.

---
 rtl/apb4_initiator_pkg.sv | 5 +
 rtl/apb4_cpuif_initiator.sv | 96 +++++++++
 tb/tb_apb4_cpuif_initiator.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/apb4_initiator_pkg.sv
// apb4_initiator_pkg: FSM state encoding and APB4 defaults shared by the initiator
package apb4_initiator_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;
  localparam logic [2:0] PROT_DEFAULT = 3'b000;
endpackage

// File: rtl/apb4_cpuif_initiator.sv
// apb4_cpuif_initiator: turns valid/ready commands into APB4 transfers, with a PREADY watchdog
module apb4_cpuif_initiator
  import apb4_initiator_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  input  logic [2:0]              req_prot,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic                    resp_timeout,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [2:0]              pprot,
  input  logic                    pready,
  input  logic                    pslverr,
  input  logic [DATA_WIDTH-1:0]   prdata
);
  localparam bit WD_EN = TIMEOUT_CYCLES > 0;
  localparam int CW = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          wd_fire;
  assign req_ready = state_q == IDLE;
  assign wd_fire   = WD_EN && cnt_q == CNT_LAST;
  // Transfer sequencer; the APB command registers double as the bus outputs so they stay stable through ACCESS
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      psel         <= 1'b0;
      penable      <= 1'b0;
      pwrite       <= 1'b0;
      paddr        <= '0;
      pwdata       <= '0;
      pstrb        <= '0;
      pprot        <= PROT_DEFAULT;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      resp_timeout <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          paddr   <= req_addr;
          pwrite  <= req_write;
          pwdata  <= req_write ? req_wdata : '0;
          pstrb   <= req_write ? req_wstrb : '0;
          pprot   <= req_prot;
          psel    <= 1'b1;
          cnt_q   <= '0;
          state_q <= SETUP;
        end
        SETUP: begin
          penable <= 1'b1;
          state_q <= ACCESS;
        end
        ACCESS: if (pready || wd_fire) begin
          psel         <= 1'b0;
          penable      <= 1'b0;
          resp_valid   <= 1'b1;
          resp_err     <= !pready || pslverr;
          resp_timeout <= !pready;
          resp_rdata   <= (pready && !pwrite && !pslverr) ? prdata : '0;
          state_q      <= RESP;
        end else if (cnt_q != '1) begin
          cnt_q <= cnt_q + 1'b1;
        end
        RESP: if (resp_ready) begin
          resp_valid   <= 1'b0;
          resp_err     <= 1'b0;
          resp_timeout <= 1'b0;
          resp_rdata   <= '0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb4_cpuif_initiator.sv
// tb_apb4_cpuif_initiator: directed table plus randomized transfers checked against a transaction-level model
module tb_apb4_cpuif_initiator;
  localparam int TMO = 8;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic [2:0]  req_prot;
  logic        resp_valid, resp_ready, resp_err, resp_timeout;
  logic [31:0] resp_rdata;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        pready, pslverr;
  logic [31:0] prdata;
  int checks = 0;
  int fails = 0;
  typedef struct {
    bit wr;
    logic [31:0] addr, wdata;
    logic [3:0] strb;
    logic [2:0] prot;
    int waits;
    bit slverr;
    logic [31:0] prdata;
    int rdelay;
    logic [31:0] e_rdata;
    bit e_err, e_to;
    int e_lat;
  } vec_t;
  apb4_cpuif_initiator #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_prot(req_prot),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .resp_timeout(resp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pstrb(pstrb), .pprot(pprot), .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Transaction-level expectation: waits >= TMO means the responder never answers in time
  function automatic vec_t model(input vec_t v);
    bit to;
    to = v.waits >= TMO;
    v.e_to = to;
    v.e_err = to || v.slverr;
    v.e_rdata = (v.wr || v.slverr || to) ? 32'h0 : v.prdata;
    v.e_lat = (to ? TMO : v.waits + 1) + 2;
    return v;
  endfunction
  task automatic xfer(input vec_t v, input string tag);
    int lat, acc, g;
    req_valid = 1'b1;
    req_write = v.wr;
    req_addr = v.addr;
    req_wdata = v.wdata;
    req_wstrb = v.strb;
    req_prot = v.prot;
    g = 0;
    while (!req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk({tag, " accept"}, 128'(req_ready), 128'(1));
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr = 32'($urandom);
    req_wdata = 32'($urandom);
    req_wstrb = 4'($urandom);
    req_prot = 3'($urandom);
    lat = 1;
    acc = 0;
    while (!resp_valid && lat < 40) begin
      chk({tag, " phase"}, 128'({psel, penable}), 128'({1'b1, lat > 1}));
      chk({tag, " apb"}, 128'({paddr, pwrite, pwdata, pstrb, pprot}),
          128'({v.addr, v.wr, (v.wr ? v.wdata : 32'h0), (v.wr ? v.strb : 4'h0), v.prot}));
      if (psel && penable) begin
        pready = acc == v.waits;
        pslverr = pready ? v.slverr : 1'($urandom);
        prdata = pready ? v.prdata : 32'($urandom);
        acc++;
      end else begin
        pready = 1'($urandom);
        pslverr = 1'($urandom);
        prdata = 32'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    pready = 1'b0;
    pslverr = 1'b0;
    chk({tag, " latency"}, 128'(lat), 128'(v.e_lat));
    for (int i = 0; i <= v.rdelay; i++) begin
      chk({tag, " resp"}, 128'({resp_valid, resp_err, resp_timeout, resp_rdata}),
          128'({1'b1, v.e_err, v.e_to, v.e_rdata}));
      chk({tag, " resp_bus"}, 128'({psel, penable, req_ready}), 128'(0));
      if (i == v.rdelay) resp_ready = 1'b1;
      @(negedge clk);
    end
    resp_ready = 1'b0;
    chk({tag, " release"}, 128'({req_ready, resp_valid, psel}), 128'(3'b100));
  endtask
  initial begin
    vec_t tbl[6];
    vec_t v;
    int g;
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0; req_prot = '0;
    resp_ready = 1'b0; pready = 1'b0; pslverr = 1'b0; prdata = '0;
    repeat (3) @(negedge clk);
    chk("reset ctl", 128'({psel, penable, pwrite, resp_valid, resp_err, resp_timeout}), 128'(0));
    chk("reset data", 128'({paddr, pwdata, pstrb, pprot, resp_rdata}), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("post reset ready", 128'({req_ready, resp_valid, psel}), 128'(3'b100));
    tbl[0] = '{wr:1, addr:32'h4, wdata:32'hA5A5_0001, strb:4'hF, prot:3'b000, waits:0, slverr:0,
               prdata:32'h1234_5678, rdelay:0, e_rdata:32'h0, e_err:0, e_to:0, e_lat:3};
    tbl[1] = '{wr:0, addr:32'h10, wdata:32'h5555_AAAA, strb:4'hF, prot:3'b010, waits:3, slverr:0,
               prdata:32'hDEAD_BEEF, rdelay:1, e_rdata:32'hDEAD_BEEF, e_err:0, e_to:0, e_lat:6};
    tbl[2] = '{wr:0, addr:32'h20, wdata:32'h0, strb:4'h0, prot:3'b001, waits:1, slverr:1,
               prdata:32'hCAFE_F00D, rdelay:0, e_rdata:32'h0, e_err:1, e_to:0, e_lat:4};
    tbl[3] = '{wr:0, addr:32'h30, wdata:32'h0, strb:4'h0, prot:3'b000, waits:20, slverr:0,
               prdata:32'h0000_0001, rdelay:0, e_rdata:32'h0, e_err:1, e_to:1, e_lat:10};
    tbl[4] = '{wr:1, addr:32'h34, wdata:32'h0BAD_F00D, strb:4'h5, prot:3'b101, waits:2, slverr:0,
               prdata:32'hFFFF_FFFF, rdelay:5, e_rdata:32'h0, e_err:0, e_to:0, e_lat:5};
    tbl[5] = '{wr:1, addr:32'h38, wdata:32'h1357_9BDF, strb:4'h3, prot:3'b111, waits:7, slverr:1,
               prdata:32'h2468_ACE0, rdelay:2, e_rdata:32'h0, e_err:1, e_to:0, e_lat:10};
    for (int i = 0; i < 6; i++) xfer(tbl[i], $sformatf("vec%0d", i));
    for (int i = 0; i < 40; i++) begin
      v.wr = 1'($urandom);
      v.addr = 32'($urandom) & 32'h0000_FFFC;
      v.wdata = 32'($urandom);
      v.strb = 4'($urandom);
      v.prot = 3'($urandom);
      v.waits = $urandom_range(0, 10);
      v.slverr = ($urandom_range(0, 3) == 0);
      v.prdata = 32'($urandom);
      v.rdelay = $urandom_range(0, 3);
      v = model(v);
      xfer(v, $sformatf("rnd%0d", i));
    end
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_wdata = 32'hFACE_0000;
    req_wstrb = 4'hC; req_prot = 3'b011;
    g = 0;
    while (!req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst seq access", 128'({psel, penable}), 128'(2'b11));
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst seq ctl", 128'({psel, penable, pwrite, resp_valid, resp_err, resp_timeout}), 128'(0));
    chk("rst seq data", 128'({paddr, pwdata, pstrb, pprot, resp_rdata}), 128'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst seq idle", 128'({req_ready, resp_valid, psel}), 128'(3'b100));
    end
    v = '{wr:0, addr:32'h44, wdata:32'h0, strb:4'hF, prot:3'b000, waits:0, slverr:0,
          prdata:32'h0F0F_1234, rdelay:0, e_rdata:32'h0, e_err:0, e_to:0, e_lat:0};
    xfer(model(v), "after_rst");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
